// File: rtl/qerv_pkg.sv
// Shared constants and elaboration helpers for the parametrised qerv buffer register.
package qerv_pkg;

    localparam logic [1:0] LS_BYTE = 2'b00;
    localparam logic [1:0] LS_HALF = 2'b01;
    localparam logic [1:0] LS_WORD = 2'b10;

    function automatic bit qerv_w_legal(input int w);
        return (w == 1) || (w == 2) || (w == 4) || (w == 8);
    endfunction

    // Width of the sub-chunk shift amount; W=1 still needs a 1-bit port.
    function automatic int qerv_lb(input int w);
        return (w <= 2) ? 1 : $clog2(w);
    endfunction

endpackage

// File: rtl/qerv_bufreg_par_if.sv
// Control/data bundle between the qerv core and its W-bit buffer register.
interface qerv_bufreg_par_if
    import qerv_pkg::*;
#(
    parameter int W  = 4,
    parameter int LB = qerv_lb(W)
) ();

    logic          i_cnt0;
    logic          i_en;
    logic          i_init;
    logic          i_mdu_op;
    logic          i_rs1_en;
    logic          i_imm_en;
    logic          i_clr_lsb;
    logic          i_shift_op;
    logic          i_right_shift_op;
    logic          i_sh_signed;
    logic [1:0]    i_ls_size;
    logic [W-1:0]  i_rs1;
    logic [W-1:0]  i_imm;
    logic [LB-1:0] i_shamt_lsb;

    logic [W-1:0]  o_q;
    logic [1:0]    o_lsb;
    logic          o_last;
    logic          o_misalign;
    logic [31:0]   o_dbus_adr;
    logic [31:0]   o_ext_rs1;

    modport master (
        output i_cnt0, i_en, i_init, i_mdu_op, i_rs1_en, i_imm_en, i_clr_lsb,
               i_shift_op, i_right_shift_op, i_sh_signed, i_ls_size,
               i_rs1, i_imm, i_shamt_lsb,
        input  o_q, o_lsb, o_last, o_misalign, o_dbus_adr, o_ext_rs1
    );

    modport slave (
        input  i_cnt0, i_en, i_init, i_mdu_op, i_rs1_en, i_imm_en, i_clr_lsb,
               i_shift_op, i_right_shift_op, i_sh_signed, i_ls_size,
               i_rs1, i_imm, i_shamt_lsb,
        output o_q, o_lsb, o_last, o_misalign, o_dbus_adr, o_ext_rs1
    );

endinterface

// File: rtl/qerv_bufreg_shifter.sv
// Sub-chunk shifter for the buffer register output: applies s within a W-bit chunk
// and carries the displaced high bits into the next beat through the spill register.
module qerv_bufreg_shifter #(
    parameter int W  = 4,
    parameter int LB = 2
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_en,
    input  logic          i_cnt0,
    input  logic          i_shift_op,
    input  logic          i_right_shift_op,
    input  logic [LB-1:0] i_shamt_lsb,
    input  logic [W-1:0]  i_d,
    output logic [W-1:0]  o_q
);

    logic [LB-1:0]  s;
    logic [2*W-1:0] ext;
    logic [W-1:0]   spill;

    // A right shift by n is a left shift by W-n followed by dropping one chunk upstream.
    always_comb begin
        s = '0;
        if (i_shift_op) begin
            if (!i_right_shift_op)
                s = i_shamt_lsb;
            else if (i_shamt_lsb != '0)
                s = LB'(W - int'(i_shamt_lsb));
        end
        if (W == 1)
            s = '0;
    end

    always_comb begin
        ext = {{W{1'b0}}, i_d} << s;
        o_q = i_en ? (ext[W-1:0] | spill) : '0;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)
            spill <= '0;
        else if (i_en)
            spill <= ext[2*W-1:W];
        else if (i_cnt0)
            spill <= '0;
    end

endmodule

// File: rtl/qerv_bufreg_par.sv
// Bit-serial buffer register, W bits per beat: rs1+imm address adder, rs1 holding
// for shifts/MDU, streamed output through the sub-chunk shifter.
module qerv_bufreg_par
    import qerv_pkg::*;
#(
    parameter int W   = 4,
    parameter int MDU = 0,
    parameter int LB  = qerv_lb(W)
) (
    input logic              i_clk,
    input logic              i_rst_n,
    qerv_bufreg_par_if.slave bus
);

    localparam int BEATS = 32 / W;
    localparam int BW    = $clog2(BEATS);

    if (!qerv_w_legal(W)) begin : g_bad_w
        $error("qerv_bufreg_par: W must be 1, 2, 4 or 8");
    end

    logic [31:0]   data;
    logic          c_r;
    logic [1:0]    lsb;
    logic [BW-1:0] beat;

    logic [W-1:0]  rs1_g;
    logic [W-1:0]  imm_g;
    logic [W-1:0]  sum;
    logic [W-1:0]  fill;
    logic          c;

    always_comb begin
        rs1_g = bus.i_rs1_en ? bus.i_rs1 : '0;
        imm_g = bus.i_imm_en ? bus.i_imm : '0;
        if (bus.i_cnt0 && bus.i_clr_lsb)
            imm_g[0] = 1'b0;
        {c, sum} = {1'b0, rs1_g} + {1'b0, imm_g} + {{W{1'b0}}, c_r};
        fill = bus.i_sh_signed ? {W{data[31]}} : '0;
    end

    // Carry is re-evaluated every clock, so any idle cycle drops it.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            data <= '0;
            c_r  <= 1'b0;
            beat <= '0;
        end else begin
            c_r <= c & bus.i_en;
            if (bus.i_en) begin
                data <= {bus.i_init ? sum : fill, data[31:W]};
                beat <= bus.i_cnt0 ? BW'(1) : beat + BW'(1);
            end
        end
    end

    if (W >= 2) begin : g_lsb_wide
        always_ff @(posedge i_clk or negedge i_rst_n) begin
            if (!i_rst_n)
                lsb <= '0;
            else if (bus.i_en && bus.i_cnt0)
                lsb <= sum[1:0];
        end
    end else begin : g_lsb_serial
        // One bit per beat: bit 0 on the cnt0 beat, bit 1 on the beat after.
        always_ff @(posedge i_clk or negedge i_rst_n) begin
            if (!i_rst_n)
                lsb <= '0;
            else if (bus.i_en) begin
                if (bus.i_cnt0)
                    lsb[0] <= sum[0];
                else if (beat == BW'(1))
                    lsb[1] <= sum[0];
            end
        end
    end

    always_comb begin
        bus.o_misalign = 1'b0;
        case (bus.i_ls_size)
            LS_HALF: bus.o_misalign = lsb[0];
            LS_WORD: bus.o_misalign = |lsb;
            default: bus.o_misalign = 1'b0;
        endcase
    end

    assign bus.o_lsb      = ((MDU != 0) && bus.i_mdu_op) ? 2'b00 : lsb;
    assign bus.o_last     = bus.i_en & (bus.i_cnt0 ? (BEATS == 1)
                                                   : (beat == BW'(BEATS - 1)));
    assign bus.o_dbus_adr = {data[31:2], 2'b00};
    assign bus.o_ext_rs1  = {data[31:2], lsb};

    qerv_bufreg_shifter #(
        .W  (W),
        .LB (LB)
    ) u_shifter (
        .i_clk            (i_clk),
        .i_rst_n          (i_rst_n),
        .i_en             (bus.i_en),
        .i_cnt0           (bus.i_cnt0),
        .i_shift_op       (bus.i_shift_op),
        .i_right_shift_op (bus.i_right_shift_op),
        .i_shamt_lsb      (bus.i_shamt_lsb),
        .i_d              (data[W-1:0]),
        .o_q              (bus.o_q)
    );

endmodule

// File: tb/tb_qerv_bufreg_par.sv
// Bench for qerv_bufreg_par: W=1, W=4 (MDU=1) and W=8 instances against a 32-bit word model.
module tb_qerv_bufreg_par;
    import qerv_pkg::*;

    logic i_clk = 1'b0;
    logic i_rst_n;
    always #5 i_clk = ~i_clk;

    logic        en_c, cnt0_c, init_c, mdu_c, rs1en_c, immen_c, clr_c;
    logic        shop_c, right_c, sgn_c;
    logic [1:0]  lss_c;
    logic [31:0] rs1_w, imm_w;
    logic [2:0]  shamt_c;
    int          bi, sel;

    qerv_bufreg_par_if #(.W(1)) b1 ();
    qerv_bufreg_par_if #(.W(4)) b4 ();
    qerv_bufreg_par_if #(.W(8)) b8 ();

    assign b1.i_en = en_c & (sel == 1);         assign b1.i_cnt0 = cnt0_c & (sel == 1);
    assign b4.i_en = en_c & (sel == 4);         assign b4.i_cnt0 = cnt0_c & (sel == 4);
    assign b8.i_en = en_c & (sel == 8);         assign b8.i_cnt0 = cnt0_c & (sel == 8);
    assign b1.i_rs1 = 1'(rs1_w >> bi);          assign b1.i_imm = 1'(imm_w >> bi);
    assign b4.i_rs1 = 4'(rs1_w >> (bi * 4));    assign b4.i_imm = 4'(imm_w >> (bi * 4));
    assign b8.i_rs1 = 8'(rs1_w >> (bi * 8));    assign b8.i_imm = 8'(imm_w >> (bi * 8));
    assign b1.i_shamt_lsb = shamt_c[0];
    assign b4.i_shamt_lsb = shamt_c[1:0];
    assign b8.i_shamt_lsb = shamt_c[2:0];
    assign {b1.i_init, b4.i_init, b8.i_init} = {3{init_c}};
    assign {b1.i_mdu_op, b4.i_mdu_op, b8.i_mdu_op} = {3{mdu_c}};
    assign {b1.i_rs1_en, b4.i_rs1_en, b8.i_rs1_en} = {3{rs1en_c}};
    assign {b1.i_imm_en, b4.i_imm_en, b8.i_imm_en} = {3{immen_c}};
    assign {b1.i_clr_lsb, b4.i_clr_lsb, b8.i_clr_lsb} = {3{clr_c}};
    assign {b1.i_shift_op, b4.i_shift_op, b8.i_shift_op} = {3{shop_c}};
    assign {b1.i_right_shift_op, b4.i_right_shift_op, b8.i_right_shift_op} = {3{right_c}};
    assign {b1.i_sh_signed, b4.i_sh_signed, b8.i_sh_signed} = {3{sgn_c}};
    assign b1.i_ls_size = lss_c;
    assign b4.i_ls_size = lss_c;
    assign b8.i_ls_size = lss_c;

    qerv_bufreg_par #(.W(1), .MDU(0)) dut1 (.i_clk(i_clk), .i_rst_n(i_rst_n), .bus(b1.slave));
    qerv_bufreg_par #(.W(4), .MDU(1)) dut4 (.i_clk(i_clk), .i_rst_n(i_rst_n), .bus(b4.slave));
    qerv_bufreg_par #(.W(8), .MDU(0)) dut8 (.i_clk(i_clk), .i_rst_n(i_rst_n), .bus(b8.slave));

    logic [31:0] q_act[3], adr_act[3], ext_act[3];
    logic [1:0]  lsb_act[3];
    logic        last_act[3], mis_act[3];

    always_comb begin
        q_act[0] = 32'(b1.o_q);  q_act[1] = 32'(b4.o_q);  q_act[2] = 32'(b8.o_q);
        adr_act[0] = b1.o_dbus_adr; adr_act[1] = b4.o_dbus_adr; adr_act[2] = b8.o_dbus_adr;
        ext_act[0] = b1.o_ext_rs1;  ext_act[1] = b4.o_ext_rs1;  ext_act[2] = b8.o_ext_rs1;
        lsb_act[0] = b1.o_lsb;  lsb_act[1] = b4.o_lsb;  lsb_act[2] = b8.o_lsb;
        last_act[0] = b1.o_last; last_act[1] = b4.o_last; last_act[2] = b8.o_last;
        mis_act[0] = b1.o_misalign; mis_act[1] = b4.o_misalign; mis_act[2] = b8.o_misalign;
    end

    // Word-level model: architectural 32-bit contents, pending spill bits, captured lsb.
    logic [31:0] m_data[3], m_spill[3];
    logic [1:0]  m_lsb[3];
    logic [31:0] exp_q[3];
    logic        exp_last[3];
    bit          chk_dyn, chk_st;
    int          checks, failures;
    int          wk[3] = '{1, 4, 8};
    logic [31:0] q_word;
    int          last_cnt, last_beat;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s act=%h exp=%h", name, act, exp);
        end
    endtask

    function automatic logic mis_model(input logic [1:0] l, input logic [1:0] sz);
        return ((sz == LS_HALF) && l[0]) || ((sz == LS_WORD) && (l != 2'b00));
    endfunction

    always @(negedge i_clk) begin
        if (chk_dyn)
            for (int k = 0; k < 3; k++) begin
                check($sformatf("q_w%0d", wk[k]), q_act[k], exp_q[k]);
                check($sformatf("last_w%0d", wk[k]), 32'(last_act[k]), 32'(exp_last[k]));
            end
        if (chk_st)
            for (int k = 0; k < 3; k++) begin
                check($sformatf("adr_w%0d", wk[k]), adr_act[k], {m_data[k][31:2], 2'b00});
                check($sformatf("ext_w%0d", wk[k]), ext_act[k], {m_data[k][31:2], m_lsb[k]});
                check($sformatf("lsb_w%0d", wk[k]), 32'(lsb_act[k]),
                      (k == 1 && mdu_c) ? 32'd0 : 32'(m_lsb[k]));
                check($sformatf("mis_w%0d", wk[k]), 32'(mis_act[k]),
                      32'(mis_model(m_lsb[k], lss_c)));
            end
    end

    task automatic clear_exp();
        for (int j = 0; j < 3; j++) begin
            exp_q[j] = '0;
            exp_last[j] = 1'b0;
        end
    endtask

    // One full 32-bit pass on the selected instance; control globals set by the caller.
    task automatic run_pass(input int w, input logic [31:0] rs1, input logic [31:0] imm);
        int k, n, s, sh;
        logic [63:0] stream;
        logic [31:0] msk, rg, ig, sum, d;
        k   = (w == 1) ? 0 : (w == 4) ? 1 : 2;
        n   = 32 / w;
        msk = (32'd1 << w) - 32'd1;
        sh  = int'(shamt_c) % w;
        s   = (!shop_c || w == 1) ? 0 : (!right_c ? sh : (sh == 0 ? 0 : w - sh));
        d   = m_data[k];
        stream = ({32'b0, d} << s) | {32'b0, m_spill[k]};
        rg  = rs1en_c ? rs1 : 32'd0;
        ig  = immen_c ? (clr_c ? (imm & ~32'd1) : imm) : 32'd0;
        sum = rg + ig;
        q_word = '0; last_cnt = 0; last_beat = -1;
        for (int b = 0; b < n; b++) begin
            @(posedge i_clk); #1;
            sel = w; rs1_w = rs1; imm_w = imm; bi = b;
            en_c = 1'b1; cnt0_c = (b == 0);
            chk_st = 1'b0;
            clear_exp();
            exp_q[k]    = 32'(stream >> (b * w)) & msk;
            exp_last[k] = (b == n - 1);
            chk_dyn = 1'b1;
            @(negedge i_clk); #1;
            q_word = q_word | ((q_act[k] & msk) << (b * w));
            if (last_act[k]) begin
                last_cnt++;
                last_beat = b;
            end
        end
        @(posedge i_clk); #1;
        en_c = 1'b0; cnt0_c = 1'b0; bi = 0;
        clear_exp();
        m_data[k]  = init_c ? sum : ((sgn_c && d[31]) ? 32'hFFFF_FFFF : 32'h0);
        m_spill[k] = 32'(stream >> 32) & msk;
        m_lsb[k]   = sum[1:0];
        chk_st = 1'b1;
        @(negedge i_clk); #1;
    endtask

    task automatic clear_spill(input int w);
        @(posedge i_clk); #1;
        sel = w; cnt0_c = 1'b1; en_c = 1'b0;
        @(posedge i_clk); #1;
        cnt0_c = 1'b0;
        m_spill[(w == 1) ? 0 : (w == 4) ? 1 : 2] = '0;
        @(negedge i_clk); #1;
    endtask

    task automatic set_ctl(input bit init, input bit r1, input bit im, input bit shop,
                           input bit right, input bit sgn, input logic [2:0] shamt);
        init_c = init; rs1en_c = r1; immen_c = im; shop_c = shop;
        right_c = right; sgn_c = sgn; shamt_c = shamt;
    endtask

    initial begin
        i_rst_n = 1'b0;
        en_c = 0; cnt0_c = 0; mdu_c = 0; clr_c = 0;
        set_ctl(0, 0, 0, 0, 0, 0, 3'd0);
        lss_c = LS_BYTE; rs1_w = '0; imm_w = '0; bi = 0; sel = 0;
        chk_dyn = 0; chk_st = 0; checks = 0; failures = 0;
        for (int k = 0; k < 3; k++) begin
            m_data[k] = '0; m_spill[k] = '0; m_lsb[k] = '0;
        end
        clear_exp();

        #12;
        for (int k = 0; k < 3; k++) begin
            check("rst_q", q_act[k], 32'd0);
            check("rst_adr", adr_act[k], 32'd0);
            check("rst_lsb", 32'(lsb_act[k]), 32'd0);
            check("rst_last", 32'(last_act[k]), 32'd0);
            check("rst_mis", 32'(mis_act[k]), 32'd0);
        end
        i_rst_n = 1'b1;
        @(negedge i_clk); #1;
        chk_dyn = 1; chk_st = 1;

        // Load address: 0x1000_0003 + 5
        set_ctl(1, 1, 1, 0, 0, 0, 3'd0);
        run_pass(4, 32'h1000_0003, 32'h5);
        check("t1_adr", adr_act[1], 32'h1000_0008);
        check("t1_lsb", 32'(lsb_act[1]), 32'd0);
        check("t1_last_cnt", 32'(last_cnt), 32'd1);
        check("t1_last_beat", 32'(last_beat), 32'd7);

        // JALR: 0x100 + (7 & ~1)
        clr_c = 1;
        run_pass(4, 32'h100, 32'h7);
        clr_c = 0;
        check("t2_adr", adr_act[1], 32'h104);
        check("t2_lsb", 32'(lsb_act[1]), 32'd2);
        lss_c = LS_WORD; #1;
        check("t2_mis_word", 32'(mis_act[1]), 32'd1);
        @(negedge i_clk); #1;
        lss_c = LS_HALF; #1;
        check("t2_mis_half", 32'(mis_act[1]), 32'd0);
        @(negedge i_clk); #1;
        lss_c = 2'b11; #1;
        check("t2_mis_rsvd", 32'(mis_act[1]), 32'd0);
        lss_c = LS_BYTE;
        mdu_c = 1; #1;
        check("mdu_lsb", 32'(lsb_act[1]), 32'd0);
        @(negedge i_clk); #1;
        mdu_c = 0;

        // Left shift by 1 within the chunk
        set_ctl(1, 1, 0, 0, 0, 0, 3'd0);
        run_pass(4, 32'h8000_0001, 32'h0);
        set_ctl(0, 0, 0, 1, 0, 0, 3'd1);
        run_pass(4, 32'h0, 32'h0);
        check("t3_qword", q_word, 32'h0000_0002);

        // Arithmetic vs logical fill
        set_ctl(1, 1, 0, 0, 0, 0, 3'd0);
        run_pass(4, 32'h8000_0000, 32'h0);
        set_ctl(0, 0, 0, 0, 0, 1, 3'd0);
        run_pass(4, 32'h0, 32'h0);
        check("t4_adr_signed", adr_act[1], 32'hFFFF_FFFC);
        set_ctl(0, 0, 0, 0, 0, 0, 3'd0);
        run_pass(4, 32'h0, 32'h0);
        check("t4_qword_ones", q_word, 32'hFFFF_FFFF);
        check("t4_adr_zero", adr_act[1], 32'h0);

        // Right shift by 1 (s=3) leaves spill bits that leak into the next pass
        set_ctl(1, 1, 0, 0, 0, 0, 3'd0);
        run_pass(4, 32'hF234_5678, 32'h0);
        set_ctl(0, 0, 0, 1, 1, 0, 3'd1);
        run_pass(4, 32'h0, 32'h0);
        check("rs_qword", q_word, 32'h91A2_B3C0);
        set_ctl(1, 1, 0, 0, 0, 0, 3'd0);
        run_pass(4, 32'h0, 32'h0);
        check("rs_spill_feed", q_word, 32'h0000_0007);

        // W=8 right shift by 3 (s=5): spill 0x1E, then cleared by an idle cnt0
        run_pass(8, 32'hF234_5678, 32'h0);
        set_ctl(0, 0, 0, 1, 1, 0, 3'd3);
        run_pass(8, 32'h0, 32'h0);
        check("w8_rs_qword", q_word, 32'h468A_CF00);
        set_ctl(1, 1, 0, 0, 0, 0, 3'd0);
        run_pass(8, 32'h0, 32'h0);
        check("w8_spill_feed", q_word, 32'h0000_001E);
        run_pass(8, 32'h0, 32'h0);
        set_ctl(0, 0, 0, 1, 1, 0, 3'd3);
        run_pass(8, 32'h8000_0000, 32'h0);
        clear_spill(8);
        set_ctl(1, 1, 0, 0, 0, 0, 3'd0);
        run_pass(8, 32'h0, 32'h0);
        check("w8_spill_clr", q_word, 32'h0);

        // Serial and wide lsb capture
        set_ctl(1, 1, 1, 0, 0, 0, 3'd0);
        run_pass(1, 32'h7, 32'h0);
        check("t5_w1_lsb", 32'(lsb_act[0]), 32'd3);
        check("t5_w1_adr", adr_act[0], 32'h4);
        check("t5_w1_last_cnt", 32'(last_cnt), 32'd1);
        check("t5_w1_last_beat", 32'(last_beat), 32'd31);
        run_pass(8, 32'h7, 32'h0);
        check("t5_w8_lsb", 32'(lsb_act[2]), 32'd3);
        check("t5_w8_last_cnt", 32'(last_cnt), 32'd1);
        check("t5_w8_last_beat", 32'(last_beat), 32'd3);
        lss_c = LS_WORD;
        @(negedge i_clk); #1;
        lss_c = LS_BYTE;

        // Reset in the middle of a carry-heavy pass
        set_ctl(1, 1, 1, 1, 0, 0, 3'd2);
        chk_dyn = 0; chk_st = 0;
        for (int b = 0; b < 4; b++) begin
            @(posedge i_clk); #1;
            sel = 4; en_c = 1; cnt0_c = (b == 0);
            rs1_w = 32'hFFFF_FFFF; imm_w = 32'h1; bi = b;
        end
        #2 i_rst_n = 1'b0;
        #1;
        check("t6_q", q_act[1], 32'd0);
        check("t6_lsb", 32'(lsb_act[1]), 32'd0);
        check("t6_adr", adr_act[1], 32'd0);
        check("t6_last", 32'(last_act[1]), 32'd0);
        check("t6_mis", 32'(mis_act[1]), 32'd0);
        check("t6_ext", ext_act[1], 32'd0);
        en_c = 0; cnt0_c = 0; bi = 0;
        for (int k = 0; k < 3; k++) begin
            m_data[k] = '0; m_spill[k] = '0; m_lsb[k] = '0;
        end
        clear_exp();
        @(negedge i_clk);
        i_rst_n = 1'b1;
        #1;
        chk_dyn = 1; chk_st = 1;
        set_ctl(1, 1, 1, 0, 0, 0, 3'd0);
        run_pass(4, 32'h1000_0003, 32'h5);
        check("t6_adr_after", adr_act[1], 32'h1000_0008);
        check("t6_qword_after", q_word, 32'h0);

        chk_dyn = 0; chk_st = 0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
